// File: rtl/riscv_icache_responder_pkg.sv
// Shared encodings for the instruction-fetch responder: FSM states, privilege levels
// and the request-queue entry width.
package riscv_icache_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StResp,
        StDrain
    } state_e;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Queue entry is {pc[31:0], priv[1:0]}.
    localparam int unsigned ENTRY_W = 34;

endpackage

// File: rtl/riscv_icache_req_fifo.sv
// Synchronous request FIFO with flush; head word is readable combinationally.
module riscv_icache_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (PTR_W + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/riscv_icache_responder.sv
// Fetch-side responder: queues requests, checks alignment/privilege, serves repeats from a
// one-word last-fetch buffer and otherwise reads instruction memory, answering in order.
module riscv_icache_responder
    import riscv_icache_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] USER_BASE = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        icache_rd_i,
    input  logic [31:0] icache_pc_i,
    input  logic [1:0]  icache_priv_i,
    input  logic        icache_flush_i,
    input  logic        icache_invalidate_i,
    output logic        icache_accept_o,
    output logic        icache_valid_o,
    output logic [31:0] icache_inst_o,
    output logic        icache_error_o,
    output logic        icache_page_fault_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_error_i
);

    state_e             state;
    logic               q_full;
    logic               q_empty;
    logic               q_push;
    logic               q_pop;
    logic [ENTRY_W-1:0] q_head;
    logic [31:0]        head_pc;
    logic [1:0]         head_priv;
    logic               head_misaligned;
    logic               head_priv_fault;
    logic               head_fault;
    logic               head_hit;
    logic               miss_issue;

    logic               buf_valid;
    logic [29:0]        buf_tag;
    logic [31:0]        buf_data;

    logic               resp_valid;
    logic [31:0]        resp_inst;
    logic               resp_error;
    logic               resp_pf;

    assign icache_accept_o = rst_i && !q_full && !icache_flush_i;
    assign q_push          = icache_rd_i && icache_accept_o;
    assign q_pop           = (state == StResp) && !icache_flush_i;

    riscv_icache_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_req_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (q_push),
        .wdata ({icache_pc_i, icache_priv_i}),
        .pop   (q_pop),
        .flush (icache_flush_i),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign {head_pc, head_priv} = q_head;
    assign head_misaligned = head_pc[1:0] != 2'b00;
    assign head_priv_fault = !head_misaligned && (head_priv == PRIV_U) && (head_pc < USER_BASE);
    assign head_fault      = head_misaligned || head_priv_fault;
    assign head_hit        = buf_valid && (buf_tag == head_pc[31:2]);

    // A miss is offered to memory straight from IDLE so it goes out the cycle after accept.
    assign miss_issue = (state == StIdle) && !q_empty && !head_fault && !head_hit &&
                        !icache_flush_i;
    assign mem_rd_o   = (state == StReq) || miss_issue;
    assign mem_addr_o = mem_rd_o ? {head_pc[31:2], 2'b00} : 32'h0;

    assign icache_valid_o      = resp_valid && !icache_flush_i;
    assign icache_inst_o       = resp_inst;
    assign icache_error_o      = resp_error;
    assign icache_page_fault_o = resp_pf;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= StIdle;
            resp_valid <= 1'b0;
            resp_inst  <= 32'h0;
            resp_error <= 1'b0;
            resp_pf    <= 1'b0;
            buf_valid  <= 1'b0;
            buf_tag    <= 30'h0;
            buf_data   <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!icache_flush_i && !q_empty) begin
                        if (head_fault) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_inst  <= 32'h0;
                            resp_error <= head_misaligned;
                            resp_pf    <= head_priv_fault;
                        end else if (head_hit) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_inst  <= buf_data;
                            resp_error <= 1'b0;
                            resp_pf    <= 1'b0;
                        end else if (mem_accept_i) begin
                            state <= StWait;
                        end else begin
                            state <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (icache_flush_i) begin
                        state <= mem_accept_i ? StDrain : StIdle;
                    end else if (mem_accept_i) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack_i) begin
                        if (icache_flush_i) begin
                            state <= StIdle;
                        end else begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_inst  <= mem_data_i;
                            resp_error <= mem_error_i;
                            resp_pf    <= 1'b0;
                            if (!mem_error_i) begin
                                buf_valid <= 1'b1;
                                buf_tag   <= head_pc[31:2];
                                buf_data  <= mem_data_i;
                            end
                        end
                    end else if (icache_flush_i) begin
                        state <= StDrain;
                    end
                end
                StResp: state <= StIdle;
                StDrain: begin
                    if (mem_ack_i) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
            // Placed last so an invalidate beats a fill on the same edge.
            if (icache_invalidate_i) buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_icache_responder.sv
// Directed bench for riscv_icache_responder: vector table plus flush and backpressure sequences.
module tb_riscv_icache_responder;
    import riscv_icache_responder_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  priv;
        logic [31:0] inst;
        logic        err;
        logic        pf;
        bit          miss;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic        pf;
        int          cyc;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        rd;
    logic [31:0] pc;
    logic [1:0]  priv;
    logic        flush;
    logic        inval;
    logic        accept;
    logic        valid;
    logic [31:0] inst;
    logic        error;
    logic        pf;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_accept;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        mem_error;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_lat = 2;
    int          ack_cnt = 0;
    int          stall = 0;
    int          n_mem = 0;
    int          hs_cyc = 0;
    int          ack_cyc = 0;
    logic [31:0] lat_addr = 32'h0;
    logic [31:0] err_addr = 32'h3000;
    resp_t       resp_q[$];
    vec_t        vecs[12];

    riscv_icache_responder #(
        .DEPTH     (2),
        .USER_BASE (32'h0001_0000)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .icache_rd_i         (rd),
        .icache_pc_i         (pc),
        .icache_priv_i       (priv),
        .icache_flush_i      (flush),
        .icache_invalidate_i (inval),
        .icache_accept_o     (accept),
        .icache_valid_o      (valid),
        .icache_inst_o       (inst),
        .icache_error_o      (error),
        .icache_page_fault_o (pf),
        .mem_rd_o            (mem_rd),
        .mem_addr_o          (mem_addr),
        .mem_accept_i        (mem_accept),
        .mem_ack_i           (mem_ack),
        .mem_data_i          (mem_data),
        .mem_error_i         (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h1000) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: one outstanding read, ack ack_lat cycles after the handshake.
    initial begin
        mem_accept = 1'b0;
        mem_ack    = 1'b0;
        mem_data   = 32'h0;
        mem_error  = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_error = 1'b0;
            mem_data  = 32'h0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    mem_ack = 1'b1;
                    ack_cyc = cyc;
                    if (lat_addr == err_addr) mem_error = 1'b1;
                    else mem_data = mem_word(lat_addr);
                end
            end
            if (stall > 0) begin
                mem_accept = 1'b0;
                stall--;
            end else begin
                mem_accept = 1'b1;
            end
            #1;
            if (mem_rd && mem_accept) begin
                lat_addr = mem_addr;
                ack_cnt  = ack_lat;
                hs_cyc   = cyc;
                n_mem++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (valid) resp_q.push_back('{inst, error, pf, cyc});
        end
    end

    task automatic send(input logic [31:0] a, input logic [1:0] p, output int acc_cyc,
                        output bit waited);
        int n;
        n = 0;
        @(negedge clk);
        rd     = 1'b1;
        pc     = a;
        priv   = p;
        waited = 1'b0;
        #1;
        while (!accept && n < 100) begin
            waited = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        if (!accept) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: accept_o got 0 expected 1 for pc %h", a);
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic wait_resp(output resp_t r);
        int n;
        n = 0;
        while (resp_q.size() == 0 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        n_cmp++;
        if (resp_q.size() == 0) begin
            n_fail++;
            $display("FAIL resp_timeout: valid_o got none expected one within 100 cycles");
            r = '{32'h0, 1'b0, 1'b0, -1};
        end else begin
            r = resp_q.pop_front();
        end
    endtask

    initial begin
        int    acc;
        int    a0;
        int    a1;
        int    a2;
        bit    w;
        bit    w1;
        bit    w2;
        int    m0;
        resp_t r;
        resp_t r1;
        resp_t r2;

        vecs[0]  = '{32'h0000_1000, PRIV_M, 32'h0000_0013, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'h0000_1000, PRIV_M, 32'h0000_0013, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_2000, PRIV_U, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0001_0002, PRIV_U, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_1001, PRIV_M, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_3000, PRIV_S, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_3000, PRIV_S, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h0001_0000, PRIV_U, 32'hA5A4_0000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h0001_0000, PRIV_U, 32'hA5A4_0000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_FFFC, PRIV_U, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_2000, PRIV_S, 32'hA5A5_2000, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h0000_1000, PRIV_S, 32'h0000_0013, 1'b0, 1'b0, 1'b1};

        // Reset with a request held.
        rst   = 1'b0;
        rd    = 1'b1;
        pc    = 32'h1000;
        priv  = PRIV_M;
        flush = 1'b0;
        inval = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst accept", 32'(accept), 32'h0);
        check("rst valid", 32'(valid), 32'h0);
        check("rst inst", inst, 32'h0);
        check("rst error", 32'(error), 32'h0);
        check("rst page_fault", 32'(pf), 32'h0);
        check("rst mem_rd", 32'(mem_rd), 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd  = 1'b0;
        #1;
        check("post-rst accept", 32'(accept), 32'h1);

        for (int i = 0; i < 12; i++) begin
            m0 = n_mem;
            resp_q.delete();
            send(vecs[i].pc, vecs[i].priv, acc, w);
            wait_resp(r);
            check($sformatf("v%0d inst", i), r.inst, vecs[i].inst);
            check($sformatf("v%0d error", i), 32'(r.err), 32'(vecs[i].err));
            check($sformatf("v%0d page_fault", i), 32'(r.pf), 32'(vecs[i].pf));
            check($sformatf("v%0d mem_reads", i), 32'(n_mem - m0), vecs[i].miss ? 32'h1 : 32'h0);
            if (vecs[i].miss) begin
                check($sformatf("v%0d mem_addr", i), lat_addr, {vecs[i].pc[31:2], 2'b00});
                check($sformatf("v%0d mem_rd latency", i), 32'(hs_cyc), 32'(acc + 1));
                check($sformatf("v%0d valid after ack", i), 32'(r.cyc), 32'(ack_cyc + 1));
            end else begin
                check($sformatf("v%0d valid latency", i), 32'(r.cyc), 32'(acc + 2));
            end
        end

        // Buffer holds 0x1000: hit, then invalidate forces a memory read.
        m0 = n_mem;
        send(32'h1000, PRIV_M, acc, w);
        wait_resp(r);
        check("inv pre mem_reads", 32'(n_mem - m0), 32'h0);
        check("inv pre inst", r.inst, 32'h13);
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        m0 = n_mem;
        send(32'h1000, PRIV_M, acc, w);
        wait_resp(r);
        check("inv post mem_reads", 32'(n_mem - m0), 32'h1);
        check("inv post inst", r.inst, 32'h13);

        // Flush while the first of two queued misses waits for memory.
        ack_lat = 5;
        m0 = n_mem;
        resp_q.delete();
        send(32'h5000, PRIV_M, acc, w);
        send(32'h5004, PRIV_M, acc, w);
        check("flush pre mem_reads", 32'(n_mem - m0), 32'h1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush accept", 32'(accept), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        repeat (12) @(negedge clk);
        #3;
        check("flush valid pulses", 32'(resp_q.size()), 32'h0);
        check("flush mem_reads", 32'(n_mem - m0), 32'h1);
        ack_lat = 2;
        send(32'h4000, PRIV_M, acc, w);
        wait_resp(r);
        check("post-flush inst", r.inst, 32'hA5A5_4000);
        check("post-flush error", 32'(r.err), 32'h0);

        // Backpressure: memory stalls, third request waits for the first pop.
        @(negedge clk);
        stall = 10;
        resp_q.delete();
        send(32'h6000, PRIV_M, a0, w);
        send(32'h6004, PRIV_M, a1, w1);
        send(32'h6008, PRIV_M, a2, w2);
        check("bp 2nd waited", 32'(w1), 32'h0);
        check("bp 3rd waited", 32'(w2), 32'h1);
        wait_resp(r);
        wait_resp(r1);
        wait_resp(r2);
        check("bp 3rd accept after pop", 32'(a2), 32'(r.cyc + 1));
        check("bp resp0 inst", r.inst, 32'hA5A5_6000);
        check("bp resp1 inst", r1.inst, 32'hA5A5_6004);
        check("bp resp2 inst", r2.inst, 32'hA5A5_6008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
